// File: rtl/track_dump_ctrl.sv
// Integrate-and-dump sequencer for one channel's early/prompt/late track accumulators.
// Aligns the accumulator clear to C/A epochs and hands N-period totals to the loop processor.
module track_dump_ctrl #(
  parameter int unsigned ACC_WIDTH  = 16,
  parameter int unsigned EPOCH_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [EPOCH_BITS-1:0] coh_epochs,
  input  logic                  data_available,
  input  logic                  code_epoch,
  input  logic [ACC_WIDTH-1:0]  acc_early,
  input  logic [ACC_WIDTH-1:0]  acc_prompt,
  input  logic [ACC_WIDTH-1:0]  acc_late,
  output logic                  clear,
  output logic                  dump_valid,
  input  logic                  dump_ack,
  output logic [ACC_WIDTH-1:0]  dump_early,
  output logic [ACC_WIDTH-1:0]  dump_prompt,
  output logic [ACC_WIDTH-1:0]  dump_late,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  state_t                state;
  logic                  da_d;
  logic                  ep_d;
  logic [EPOCH_BITS-1:0] epoch_cnt;
  logic [EPOCH_BITS-1:0] last_idx;
  logic [EPOCH_BITS-1:0] coh_last;
  logic                  bnd;
  logic                  last_epoch;
  logic                  dump_event;

  // Window length is held as N-1 so a programmed 0 collapses onto a single period.
  assign coh_last   = (coh_epochs == '0) ? '0 : coh_epochs - EPOCH_BITS'(1);
  assign bnd        = da_d & ep_d;
  assign last_epoch = (epoch_cnt == last_idx);
  assign dump_event = (state == ACCUM) & enable & bnd & last_epoch;

  // Clear depends only on registered state so the accumulators see no input-to-output path.
  assign clear = (state != ACCUM) | (bnd & last_epoch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      da_d        <= 1'b0;
      ep_d        <= 1'b0;
      epoch_cnt   <= '0;
      last_idx    <= '0;
      dump_valid  <= 1'b0;
      dump_early  <= '0;
      dump_prompt <= '0;
      dump_late   <= '0;
      overrun     <= 1'b0;
    end else begin
      da_d <= data_available;
      ep_d <= code_epoch & data_available;

      // A fresh result may replace an unread one only when it is acked in the same cycle.
      if (dump_event) begin
        if (!dump_valid || dump_ack) begin
          dump_valid  <= 1'b1;
          dump_early  <= acc_early;
          dump_prompt <= acc_prompt;
          dump_late   <= acc_late;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dump_ack) begin
        dump_valid <= 1'b0;
      end

      if (!enable) begin
        state     <= IDLE;
        epoch_cnt <= '0;
        overrun   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (bnd) begin
              last_idx  <= coh_last;
              epoch_cnt <= '0;
              state     <= ACCUM;
            end
          end
          ACCUM: begin
            if (bnd) begin
              if (last_epoch) begin
                epoch_cnt <= '0;
                last_idx  <= coh_last;
              end else begin
                epoch_cnt <= epoch_cnt + EPOCH_BITS'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_track_dump_ctrl.sv
// Randomized bench for track_dump_ctrl: behavioural accumulators feed the DUT and a
// sample-level window model predicts clear, dump payloads, valid and overrun.
module tb_track_dump_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned EB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [EB-1:0] coh_epochs;
  logic          data_available;
  logic          code_epoch;
  logic [AW-1:0] acc_early;
  logic [AW-1:0] acc_prompt;
  logic [AW-1:0] acc_late;
  logic          clear;
  logic          dump_valid;
  logic          dump_ack;
  logic [AW-1:0] dump_early;
  logic [AW-1:0] dump_prompt;
  logic [AW-1:0] dump_late;
  logic          overrun;
  logic [7:0]    smp_e, smp_p, smp_l;

  always #5 clk = ~clk;

  track_dump_ctrl #(.ACC_WIDTH(AW), .EPOCH_BITS(EB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .coh_epochs(coh_epochs),
    .data_available(data_available), .code_epoch(code_epoch),
    .acc_early(acc_early), .acc_prompt(acc_prompt), .acc_late(acc_late),
    .clear(clear), .dump_valid(dump_valid), .dump_ack(dump_ack),
    .dump_early(dump_early), .dump_prompt(dump_prompt), .dump_late(dump_late),
    .overrun(overrun)
  );

  function automatic logic [AW-1:0] ext(input logic [7:0] s);
    return {{(AW-8){s[7]}}, s};
  endfunction

  // Track accumulators: one-cycle input pipe, clear loads the current sample.
  logic          a_da = 1'b0;
  logic [AW-1:0] a_se, a_sp, a_sl;
  always @(posedge clk) begin
    a_da <= data_available;
    a_se <= ext(smp_e);
    a_sp <= ext(smp_p);
    a_sl <= ext(smp_l);
    if (clear) begin
      acc_early  <= a_da ? a_se : '0;
      acc_prompt <= a_da ? a_sp : '0;
      acc_late   <= a_da ? a_sl : '0;
    end else if (a_da) begin
      acc_early  <= acc_early + a_se;
      acc_prompt <= acc_prompt + a_sp;
      acc_late   <= acc_late + a_sl;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  bit            en_r, ack_r;
  int            coh_r, ack_mode, const_prompt;
  bit            m_was_en, m_synced;
  int            m_periods, m_n;
  logic [AW-1:0] m_win [3];
  logic [AW-1:0] m_cap [3];
  logic [AW-1:0] x_dump [3];
  bit            x_vld, x_ovr;
  bit            pv_da, pv_ep;
  logic [AW-1:0] pv_s [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_was_en = 1'b0; m_synced = 1'b0; m_periods = 0; m_n = 1;
    x_vld = 1'b0; x_ovr = 1'b0; pv_da = 1'b0; pv_ep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_win[i] = '0; m_cap[i] = '0; x_dump[i] = '0; pv_s[i] = '0;
    end
  endtask

  // One clock edge of the window model, applied to the sample the DUT sees this edge.
  task automatic model_step();
    bit dump_ev;
    int n_new;
    dump_ev = 1'b0;
    n_new = (coh_r == 0) ? 1 : coh_r;
    if (!en_r) begin
      m_synced = 1'b0;
      x_ovr = 1'b0;
    end else if (m_was_en && pv_da) begin
      if (!m_synced) begin
        if (pv_ep) begin
          m_synced = 1'b1; m_n = n_new; m_periods = 0; m_win = pv_s;
        end
      end else if (pv_ep && (m_periods + 1 == m_n)) begin
        dump_ev = 1'b1; m_cap = m_win; m_win = pv_s; m_periods = 0; m_n = n_new;
      end else begin
        if (pv_ep) m_periods++;
        for (int i = 0; i < 3; i++) m_win[i] = m_win[i] + pv_s[i];
      end
    end
    m_was_en = en_r;
    if (dump_ev) begin
      if (!x_vld || ack_r) begin
        x_vld = 1'b1; x_dump = m_cap;
      end else begin
        x_ovr = 1'b1;
      end
    end else if (ack_r) begin
      x_vld = 1'b0;
    end
  endtask

  task automatic check_outputs();
    bit exp_clear;
    exp_clear = !m_synced || (pv_da && pv_ep && (m_periods + 1 == m_n));
    chk("clear", 32'(clear), 32'(exp_clear));
    chk("dump_valid", 32'(dump_valid), 32'(x_vld));
    chk("overrun", 32'(overrun), 32'(x_ovr));
    chk("dump_early", 32'(dump_early), 32'(x_dump[0]));
    chk("dump_prompt", 32'(dump_prompt), 32'(x_dump[1]));
    chk("dump_late", 32'(dump_late), 32'(x_dump[2]));
    if (const_prompt >= 0 && x_vld)
      chk("prompt_total", 32'(dump_prompt), 32'(const_prompt));
  endtask

  task automatic tick(input bit da, input bit ep, input logic [7:0] se, input logic [7:0] sp,
                      input logic [7:0] sl);
    @(negedge clk);
    check_outputs();
    case (ack_mode)
      0:       ack_r = 1'b0;
      1:       ack_r = x_vld && ($urandom_range(0, 2) == 0);
      2:       ack_r = pv_da && pv_ep;
      default: ack_r = 1'b1;
    endcase
    enable = en_r; dump_ack = ack_r; coh_epochs = EB'(coh_r);
    data_available = da; code_epoch = ep; smp_e = se; smp_p = sp; smp_l = sl;
    model_step();
    pv_da = da; pv_ep = da & ep;
    pv_s[0] = ext(se); pv_s[1] = ext(sp); pv_s[2] = ext(sl);
  endtask

  // Samples are numbered by idx; every period-th sample carries the code epoch.
  task automatic run_stream(input int start_idx, input int nsamp, input int period,
                            input int gap, input bit prompt_one);
    for (int k = 0; k < nsamp; k++) begin
      for (int g = 1; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      tick(1'b1, ((start_idx + k) % period) == 0, 8'($urandom),
           prompt_one ? 8'd1 : 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic drain(input int n);
    int saved;
    saved = ack_mode;
    ack_mode = 3;
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    ack_mode = saved;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_clear", 32'(clear), 32'd1);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_prompt", 32'(dump_prompt), 32'd0);
    model_reset();
    data_available = 1'b0; code_epoch = 1'b0; dump_ack = 1'b0; enable = en_r;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; coh_epochs = '0; data_available = 1'b0; code_epoch = 1'b0;
    dump_ack = 1'b0; smp_e = '0; smp_p = '0; smp_l = '0;
    en_r = 1'b1; ack_r = 1'b0; coh_r = 1; ack_mode = 1; const_prompt = -1;
    model_reset();
    do_reset();

    // One-period windows of 8 unit prompt samples.
    const_prompt = 8;
    run_stream(0, 80, 8, 1, 1'b1);
    chk("t1_prompt", 32'(dump_prompt), 32'd8);
    drain(4);

    // Four-period windows; coh change lands at the next dump.
    coh_r = 4;
    run_stream(0, 8, 8, 1, 1'b1);
    drain(4);
    const_prompt = 32;
    run_stream(8, 96, 8, 1, 1'b1);
    chk("t2_prompt", 32'(dump_prompt), 32'd32);
    const_prompt = -1;
    drain(4);

    // Unacked dumps overrun; ack coinciding with a dump loads the new one.
    ack_mode = 0; coh_r = 1;
    run_stream(104, 40, 8, 1, 1'b0);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_valid", 32'(dump_valid), 32'd1);
    ack_mode = 2;
    run_stream(144, 8, 8, 1, 1'b0);
    chk("t3_valid_after", 32'(dump_valid), 32'd1);
    drain(4);

    // Mid-window coh changes, including 0.
    ack_mode = 1; coh_r = 1;
    run_stream(152, 12, 8, 1, 1'b0);
    coh_r = 3;
    run_stream(164, 36, 8, 1, 1'b0);
    coh_r = 0;
    run_stream(200, 32, 8, 1, 1'b0);

    // Gapped samples.
    coh_r = 2;
    run_stream(0, 40, 5, 3, 1'b0);

    // Enable drop mid-window with a pending result.
    ack_mode = 0; coh_r = 1;
    run_stream(0, 20, 5, 1, 1'b0);
    chk("t6_overrun_pre", 32'(overrun), 32'd1);
    en_r = 1'b0;
    run_stream(20, 3, 5, 1, 1'b0);
    tick(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    chk("t6_en_clear", 32'(clear), 32'd1);
    chk("t6_en_valid", 32'(dump_valid), 32'd1);
    chk("t6_en_overrun", 32'(overrun), 32'd0);
    en_r = 1'b1; ack_mode = 1;
    run_stream(23, 30, 5, 1, 1'b0);
    ack_mode = 0;
    run_stream(53, 13, 5, 1, 1'b0);
    do_reset();
    chk("t6_rst_valid", 32'(dump_valid), 32'd0);
    ack_mode = 1; coh_r = 2;
    run_stream(0, 30, 5, 1, 1'b0);
    tick(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
